// File: rtl/mmu_req_arbiter_pkg.sv
// Shared definitions for the MMU request arbiter.
//   - arb_state_e : FSM state encoding (also exported on the debug port)
//   - DEF_*       : default parameter values for the arbiter and synchronizer
package mmu_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_LAUNCH    = 2'd2,
        ST_WAIT_FREE = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ID_W        = 2;
    localparam int DEF_VA_W        = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TMO_W       = 8;

endpackage

// File: rtl/mmu_toggle_sync.sv
// Brings the asynchronous 2-phase free toggle into the clk domain.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flops clear to 0)
//   i_async    : asynchronous toggle input
//   i_ref      : last phase already consumed by the consumer
//   o_level    : synchronized toggle level
//   o_edge     : high while o_level differs from i_ref (an unconsumed edge)
module mmu_toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    input  logic i_ref,
    output logic o_level,
    output logic o_edge
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_edge  = o_level ^ i_ref;

endmodule

// File: rtl/mmu_req_arbiter.sv
// Round-robin arbiter feeding one asynchronous MMU FIFO stage.
// One request is granted at a time, launched with a 2-phase drive toggle and
// bundled data, and the next launch waits for the stage's free toggle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_req_valid   : per-requester request (NUM_REQ)
//   i_req_vaddr   : per-requester VA, slice k = [k*VA_W +: VA_W]
//   o_req_ready   : one-hot, one-cycle accept pulse
//   o_drive       : 2-phase launch toggle to the async stage
//   o_vaddr       : bundled VA, stable from grant until the free edge
//   o_req_id      : ID of the in-flight request
//   i_free        : 2-phase free toggle from the async stage (asynchronous)
//   i_tmo_max     : WAIT_FREE timeout limit, 0 disables
//   o_busy        : FSM not in IDLE
//   o_timeout     : sticky, limit reached while waiting for free
//   o_proto_err   : sticky, free edge seen outside WAIT_FREE
//   o_dbg_state   : current FSM state
//
// Handshake: a requester raises i_req_valid[k] with a stable i_req_vaddr slice
// and holds both until o_req_ready[k] pulses; valid may drop in the ready
// cycle. The VA is captured at the decision edge, so the ready pulse only
// acknowledges, it does not sample.
module mmu_req_arbiter
    import mmu_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ID_W        = DEF_ID_W,
    parameter int VA_W        = DEF_VA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TMO_W       = DEF_TMO_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*VA_W-1:0] i_req_vaddr,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic                    o_drive,
    output logic [VA_W-1:0]         o_vaddr,
    output logic [ID_W-1:0]         o_req_id,
    input  logic                    i_free,
    input  logic [TMO_W-1:0]        i_tmo_max,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic                    o_proto_err,
    output logic [1:0]              o_dbg_state
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [VA_W-1:0]     vaddr_q, vaddr_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                drive_q, drive_d;
    logic                last_free_q, last_free_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                timeout_q, timeout_d;
    logic                proto_err_q, proto_err_d;

    logic                free_level;
    logic                free_edge;
    logic                found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     idx_v;

    mmu_toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_free_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_free),
        .i_ref   (last_free_q),
        .o_level (free_level),
        .o_edge  (free_edge)
    );

    // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx_v  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && i_req_valid[idx_v]) begin
                found  = 1'b1;
                win_id = idx_v;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        vaddr_d     = vaddr_q;
        ready_d     = '0;
        drive_d     = drive_q;
        last_free_d = last_free_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;

        // Every free edge is consumed exactly once, whatever the state; outside
        // WAIT_FREE it can only be a stage protocol violation.
        if (free_edge) begin
            last_free_d = free_level;
            if (state_q != ST_WAIT_FREE) begin
                proto_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    id_d    = win_id;
                    vaddr_d = i_req_vaddr[int'(win_id)*VA_W +: VA_W];
                    ready_d = NUM_REQ'(1) << win_id;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Toggle lands one cycle after o_vaddr became valid.
                drive_d = ~drive_q;
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_FREE;
            end
            ST_WAIT_FREE: begin
                if (free_edge) begin
                    rr_ptr_d  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    // Flag only; the request stays in flight and is never relaunched.
                    if ((i_tmo_max != '0) && (tmo_cnt_q == i_tmo_max)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            vaddr_q     <= '0;
            ready_q     <= '0;
            drive_q     <= 1'b0;
            last_free_q <= 1'b0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            vaddr_q     <= vaddr_d;
            ready_q     <= ready_d;
            drive_q     <= drive_d;
            last_free_q <= last_free_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_drive     = drive_q;
    assign o_vaddr     = vaddr_q;
    assign o_req_id    = id_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_timeout   = timeout_q;
    assign o_proto_err = proto_err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Bench for mmu_req_arbiter. The reference model is event-based: each grant
// is predicted from the set of waiting requesters and a round-robin start
// index; drive, busy, timeout and protocol-error expectations are derived from
// the cycle numbers at which grants, drive toggles and free toggles occur.
module tb_mmu_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int VA_W        = 32;
    localparam int SYNC_STAGES = 2;
    localparam int TMO_W       = 8;

    // ---------------- clock / reset / DUT ----------------
    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [VA_W-1:0]         va [NUM_REQ];
    logic [NUM_REQ*VA_W-1:0] req_vaddr;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic                    o_drive;
    logic [VA_W-1:0]         o_vaddr;
    logic [ID_W-1:0]         o_req_id;
    logic                    free = 1'b0;
    logic [TMO_W-1:0]        tmo_max = '0;
    logic                    o_busy;
    logic                    o_timeout;
    logic                    o_proto_err;
    logic [1:0]              o_dbg_state;

    always #5 clk = ~clk;

    always_comb begin
        req_vaddr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_vaddr[k*VA_W +: VA_W] = va[k];
        end
    end

    mmu_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .VA_W        (VA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TMO_W       (TMO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_vaddr (req_vaddr),
        .o_req_ready (o_req_ready),
        .o_drive     (o_drive),
        .o_vaddr     (o_vaddr),
        .o_req_id    (o_req_id),
        .i_free      (free),
        .i_tmo_max   (tmo_max),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_proto_err (o_proto_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- model state / scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [ID_W+VA_W-1:0] exp_q[$];
    int grant_log[$];
    int rr_next = 0;
    bit pending = 0;
    bit in_flight = 0;
    bit rst_prev = 1;
    logic exp_drive = 0;
    logic exp_timeout = 0;
    logic exp_proto = 0;
    int drive_at = -1, wait_start = -1, echo_at = -1, done_at = -1, proto_at = -1;
    // stimulus knobs
    int req_pct = 0;
    bit cont_mode = 0;
    bit echo_en = 1;
    int lat_min = 1, lat_max = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int start);
        logic [NUM_REQ-1:0] r;
        for (int i = 0; i < NUM_REQ; i++) begin
            r = v >> ((start + i) % NUM_REQ);
            if (r[0]) return (start + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pending = 0; in_flight = 0; rr_next = 0;
        exp_drive = 0; exp_timeout = 0; exp_proto = 0;
        drive_at = -1; wait_start = -1; echo_at = -1; done_at = -1; proto_at = -1;
    endtask

    // One clock: drive inputs for the coming edge, predict, advance, check.
    task automatic step();
        logic [ID_W-1:0]      ki;
        logic [ID_W+VA_W-1:0] e;
        logic [NUM_REQ-1:0]   exp_ready;
        int w;
        // async stage echo
        if (cyc == echo_at) begin
            free = ~free;
            echo_at = -1;
            done_at = cyc + SYNC_STAGES + 1;
        end
        // requesters
        for (int k = 0; k < NUM_REQ; k++) begin
            ki = ID_W'(k);
            if (o_req_ready[ki]) begin
                if (cont_mode) va[ki] = $urandom;
                else req_valid[ki] = 1'b0;
            end else if (!req_valid[ki] && ($urandom_range(99, 0) < req_pct)) begin
                req_valid[ki] = 1'b1;
                va[ki] = $urandom;
            end
        end
        // grant prediction for the coming edge
        if (!rst && !pending && !in_flight && (req_valid != '0)) begin
            w = pick(req_valid, rr_next);
            exp_q.push_back({ID_W'(w), va[ID_W'(w)]});
            pending = 1;
            rr_next = (w + 1) % NUM_REQ;
        end
        rst_prev = rst;

        @(posedge clk);
        #1;
        cyc++;
        exp_ready = '0;
        if (rst_prev) begin
            model_reset();
            check("rst_req_id", o_req_id, 0);
            check("rst_vaddr", o_vaddr, 0);
        end else begin
            if (cyc == done_at) begin
                in_flight = 0; done_at = -1; wait_start = -1;
            end
            if (in_flight && wait_start >= 0 && tmo_max != '0 && cyc == wait_start + int'(tmo_max) + 1)
                exp_timeout = 1;
            if (cyc == proto_at) begin
                exp_proto = 1; proto_at = -1;
            end
            if (cyc == drive_at) begin
                exp_drive = ~exp_drive;
                drive_at = -1;
                if (echo_en) echo_at = cyc + $urandom_range(lat_max, lat_min);
            end
            if (pending) begin
                pending = 0;
                e = exp_q.pop_front();
                exp_ready = NUM_REQ'(1) << e[ID_W+VA_W-1:VA_W];
                grant_log.push_back(int'(e[ID_W+VA_W-1:VA_W]));
                in_flight = 1;
                drive_at = cyc + 1;
                wait_start = cyc + 2;
                check("grant_id", o_req_id, e[ID_W+VA_W-1:VA_W]);
                check("grant_vaddr", o_vaddr, e[VA_W-1:0]);
            end
        end
        check("ready", o_req_ready, exp_ready);
        check("drive", o_drive, exp_drive);
        check("busy", o_busy, in_flight);
        check("timeout", o_timeout, exp_timeout);
        check("proto_err", o_proto_err, exp_proto);
    endtask

    task automatic drain();
        int n = 0;
        req_pct = 0; cont_mode = 0; echo_en = 1;
        while ((pending || in_flight || req_valid != '0 || echo_at >= 0) && n < 1000) begin
            step();
            n++;
        end
        check("drain_bound", (n < 1000), 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1; free = 1'b0; req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < NUM_REQ; k++) va[k] = '0;

        // 1. reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = NUM_REQ'($urandom);
            free = 1'($urandom);
            tmo_max = TMO_W'($urandom);
            step();
        end
        req_valid = '0; free = 1'b0; tmo_max = '0; rst = 1'b0;
        step();
        check("t1_busy_after_release", o_busy, 0);

        // 2. single request from requester 2
        echo_en = 1; lat_min = 1; lat_max = 1;
        req_valid[2] = 1'b1; va[2] = 32'h1234_5000;
        step();
        check("t2_ready", o_req_ready, 4'b0100);
        check("t2_vaddr", o_vaddr, 32'h1234_5000);
        check("t2_id", o_req_id, 2);
        step();
        check("t2_drive_up", o_drive, 1);
        n = 0;
        while (o_busy && n < 20) begin
            step();
            n++;
        end
        check("t2_busy_latency", n, SYNC_STAGES + 2);

        // 3. fairness, all requesters valid, echo after 5 cycles
        reset_pulse();
        grant_log.delete();
        cont_mode = 1; req_pct = 100; lat_min = 5; lat_max = 5;
        for (int k = 0; k < NUM_REQ; k++) va[k] = $urandom;
        req_valid = '1;
        n = 0;
        while (grant_log.size() < 6 && n < 300) begin
            step();
            n++;
        end
        check("t3_six_grants", (grant_log.size() >= 6), 1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("t3_order", grant_log[i], fair_exp[i]);
        end
        drain();

        // 4. timeout at 10 with no free toggle, then a late free
        tmo_max = 8'd10; echo_en = 0;
        req_valid[1] = 1'b1; va[1] = $urandom;
        for (int i = 0; i < 20; i++) step();
        check("t4_timeout_set", o_timeout, 1);
        check("t4_drive_held", o_drive, exp_drive);
        echo_at = cyc;
        drain();
        check("t4_idle_after_late_free", o_busy, 0);
        check("t4_timeout_sticky", o_timeout, 1);
        tmo_max = '0;

        // 5. free toggle while idle, then a normal request
        free = ~free;
        proto_at = cyc + SYNC_STAGES + 1;
        for (int i = 0; i < 4; i++) step();
        check("t5_proto_err", o_proto_err, 1);
        echo_en = 1; lat_min = 2; lat_max = 2;
        req_valid[0] = 1'b1; va[0] = $urandom;
        drain();
        check("t5_completes", o_busy, 0);

        // 6. reset while waiting for free
        echo_en = 0;
        req_valid[3] = 1'b1; va[3] = $urandom;
        n = 0;
        while (!(in_flight && wait_start >= 0 && cyc >= wait_start + 2) && n < 20) begin
            step();
            n++;
        end
        check("t6_reached_wait", (n < 20), 1);
        reset_pulse();
        check("t6_drive_cleared", o_drive, 0);
        check("t6_busy_cleared", o_busy, 0);
        echo_en = 1; lat_min = 1; lat_max = 3;
        req_valid[1] = 1'b1; va[1] = $urandom;
        step();
        step();
        check("t6_relaunch_drive", o_drive, 1);
        drain();

        // 7. random traffic
        req_pct = 30; cont_mode = 0; echo_en = 1; lat_min = 1; lat_max = 6;
        for (int i = 0; i < 2000; i++) step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
